// File: rtl/uart_rx_framed_pkg.sv
// Shared UART types and baud-timing helpers used by the receiver (and transmitter).
package uart_rx_framed_pkg;

  typedef enum logic [1:0] {
    ParityNone = 2'd0,
    ParityOdd  = 2'd1,
    ParityEven = 2'd2
  } uart_parity_e;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_rx_state_e;

  // Clocks per bit period.
  function automatic int unsigned baud_tick(input int unsigned clk_speed,
                                            input int unsigned baud_rate);
    return clk_speed / baud_rate;
  endfunction

  // Clocks to the centre of the start bit.
  function automatic int unsigned half_tick(input int unsigned clk_speed,
                                            input int unsigned baud_rate);
    return baud_tick(clk_speed, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_framed_sync.sv
// N-flop synchroniser for a single asynchronous input, with configurable reset value.
module uart_rx_framed_sync #(
  parameter int unsigned Stages     = 2,
  parameter logic        ResetValue = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic [Stages-1:0] r_stages;

  // Shift the async input through the flop chain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stages <= {Stages{ResetValue}};
    end else begin
      r_stages <= {r_stages[Stages-2:0], i_d};
    end
  end

  assign o_q = r_stages[Stages-1];

endmodule

// File: rtl/uart_rx_framed.sv
// UART receiver: mid-bit sampling, optional parity, 1 or 2 stop bits, valid/ready output
// with per-word error flags and overrun pulse.
module uart_rx_framed
  import uart_rx_framed_pkg::*;
#(
  parameter int unsigned CLK_SPEED = 5_000_000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data_out,
  output logic                 o_data_valid,
  input  logic                 i_data_ready,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int unsigned    BaudTick   = baud_tick(CLK_SPEED, BAUD_RATE);
  localparam int unsigned    HalfTick   = half_tick(CLK_SPEED, BAUD_RATE);
  localparam int unsigned    TickW      = $clog2(BaudTick);
  localparam logic [TickW-1:0] TickLast = TickW'(BaudTick - 1);
  localparam logic [TickW-1:0] HalfLast = TickW'(HalfTick - 1);
  localparam int unsigned    BitW       = 4;
  localparam logic [BitW-1:0] DataLast  = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0] StopLast  = BitW'(STOP_BITS - 1);
  localparam uart_parity_e   ParityMode = uart_parity_e'(PARITY[1:0]);

  uart_rx_state_e         r_state;
  logic [TickW-1:0]       r_tick;
  logic [BitW-1:0]        r_bit;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_armed;
  logic                   r_par_err;
  logic                   r_stop_err;
  logic [DATA_BITS-1:0]   r_data_out;
  logic                   r_data_valid;
  logic                   r_parity_err;
  logic                   r_frame_err;
  logic                   r_overrun;

  logic w_rx_s;
  logic w_bit_end;
  logic w_stop_err;

  uart_rx_framed_sync #(
    .Stages    (2),
    .ResetValue(1'b1)
  ) u_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .i_d    (i_rx),
    .o_q    (w_rx_s)
  );

  assign w_bit_end  = (r_tick == TickLast);
  // Error accumulates across both stop bits when STOP_BITS == 2.
  assign w_stop_err = r_stop_err | ~w_rx_s;

  // Receive FSM, tick/bit counters, shift register and output register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_tick       <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_armed      <= 1'b1;
      r_par_err    <= 1'b0;
      r_stop_err   <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      r_tick    <= r_tick + TickW'(1);
      if (r_data_valid && i_data_ready) r_data_valid <= 1'b0;
      if (w_rx_s) r_armed <= 1'b1;
      unique case (r_state)
        StIdle: begin
          r_tick <= '0;
          if (r_armed && !w_rx_s) begin
            r_state    <= StStart;
            r_bit      <= '0;
            r_par_err  <= 1'b0;
            r_stop_err <= 1'b0;
          end
        end
        StStart: begin
          if (r_tick == HalfLast) begin
            r_tick  <= '0;
            // A high sample here means the falling edge was a glitch.
            r_state <= w_rx_s ? StIdle : StData;
          end
        end
        StData: begin
          if (w_bit_end) begin
            r_tick  <= '0;
            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_bit == DataLast) begin
              r_bit   <= '0;
              r_state <= (ParityMode == ParityNone) ? StStop : StParity;
            end else begin
              r_bit <= r_bit + BitW'(1);
            end
          end
        end
        StParity: begin
          if (w_bit_end) begin
            r_tick    <= '0;
            r_par_err <= (^{r_shift, w_rx_s}) != (ParityMode == ParityOdd);
            r_state   <= StStop;
          end
        end
        StStop: begin
          if (w_bit_end) begin
            r_tick     <= '0;
            r_stop_err <= w_stop_err;
            if (r_bit == StopLast) begin
              r_bit   <= '0;
              r_state <= StIdle;
              // Stay disarmed after a bad stop so a held-low line yields one word only.
              if (w_stop_err) r_armed <= 1'b0;
              if (r_data_valid && !i_data_ready) begin
                r_overrun <= 1'b1;
              end else begin
                r_data_out   <= r_shift;
                r_parity_err <= r_par_err;
                r_frame_err  <= w_stop_err;
                r_data_valid <= 1'b1;
              end
            end else begin
              r_bit <= r_bit + BitW'(1);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_data_out   = r_data_out;
  assign o_data_valid = r_data_valid;
  assign o_parity_err = r_parity_err;
  assign o_frame_err  = r_frame_err;
  assign o_overrun    = r_overrun;
  assign o_busy       = (r_state != StIdle);

endmodule
